// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: aligns stores onto the shared data SRAM port,
// waits for the response, extends load data and hands a one-cycle result to WB.
module mem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_we,
    input  logic [1:0]        ex_size,
    input  logic              ex_signed,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              ex_ready,
    output logic              sram_req,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic [3:0]        sram_wstrb,
    input  logic              sram_gnt,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              wb_ale,
    output logic              wb_buserr,
    output logic              stall,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

    state_e            state_q;
    logic              ex_ready_q;
    logic              sram_req_q;
    logic              sram_we_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic [DATA_W-1:0] sram_wdata_q;
    logic [3:0]        sram_wstrb_q;
    logic              wb_valid_q;
    logic [DATA_W-1:0] wb_rdata_q;
    logic              wb_ale_q;
    logic              wb_buserr_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        off_q;
    logic [7:0]        cnt_q;

    logic              misaligned;
    logic [DATA_W-1:0] lane_wdata_d;
    logic [3:0]        lane_wstrb_d;

    // Byte/half sub-words sit at the lane selected by the low address bits.
    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] raw,
                                                  input logic [1:0] sz,
                                                  input logic [1:0] off,
                                                  input logic sgn);
        logic [DATA_W-1:0] sh;
        sh = raw >> {off, 3'b000};
        case (sz)
            2'd0:    extract = {{(DATA_W-8){sgn & sh[7]}}, sh[7:0]};
            2'd1:    extract = {{(DATA_W-16){sgn & sh[15]}}, sh[15:0]};
            default: extract = raw;
        endcase
    endfunction

    always_comb begin
        misaligned   = 1'b0;
        lane_wdata_d = ex_wdata;
        lane_wstrb_d = 4'hF;
        case (ex_size)
            2'd0: begin
                lane_wdata_d = {4{ex_wdata[7:0]}};
                lane_wstrb_d = 4'b0001 << ex_addr[1:0];
            end
            2'd1: begin
                misaligned   = ex_addr[0];
                lane_wdata_d = {2{ex_wdata[15:0]}};
                lane_wstrb_d = 4'b0011 << ex_addr[1:0];
            end
            default: misaligned = (ex_addr[1:0] != 2'b00);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ex_ready_q   <= 1'b1;
            sram_req_q   <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_wstrb_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rdata_q   <= '0;
            wb_ale_q     <= 1'b0;
            wb_buserr_q  <= 1'b0;
            size_q       <= '0;
            signed_q     <= 1'b0;
            off_q        <= '0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        ex_ready_q   <= 1'b0;
                        size_q       <= ex_size;
                        signed_q     <= ex_signed;
                        off_q        <= ex_addr[1:0];
                        sram_we_q    <= ex_we;
                        sram_addr_q  <= {ex_addr[ADDR_W-1:2], 2'b00};
                        sram_wdata_q <= ex_we ? lane_wdata_d : '0;
                        sram_wstrb_q <= ex_we ? lane_wstrb_d : 4'b0000;
                        if (misaligned) begin
                            state_q    <= S_RESP;
                            wb_valid_q <= 1'b1;
                            wb_ale_q   <= 1'b1;
                            wb_rdata_q <= '0;
                        end else begin
                            state_q    <= S_REQ;
                            sram_req_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (sram_gnt) begin
                        sram_req_q <= 1'b0;
                        cnt_q      <= '0;
                        if (rsp_valid) begin
                            state_q    <= S_RESP;
                            wb_valid_q <= 1'b1;
                            wb_rdata_q <= sram_we_q ? '0
                                        : extract(rsp_rdata, size_q, off_q, signed_q);
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (rsp_valid) begin
                        state_q    <= S_RESP;
                        wb_valid_q <= 1'b1;
                        wb_rdata_q <= sram_we_q ? '0
                                    : extract(rsp_rdata, size_q, off_q, signed_q);
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_q     <= S_RESP;
                        wb_valid_q  <= 1'b1;
                        wb_buserr_q <= 1'b1;
                        wb_rdata_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    // Result pulse is over; clear it and reopen for the next op.
                    state_q     <= S_IDLE;
                    ex_ready_q  <= 1'b1;
                    wb_valid_q  <= 1'b0;
                    wb_ale_q    <= 1'b0;
                    wb_buserr_q <= 1'b0;
                    wb_rdata_q  <= '0;
                end
            endcase
        end
    end

    assign ex_ready   = ex_ready_q;
    assign sram_req   = sram_req_q;
    assign sram_we    = sram_we_q;
    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_wstrb = sram_wstrb_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rdata   = wb_rdata_q;
    assign wb_ale     = wb_ale_q;
    assign wb_buserr  = wb_buserr_q;
    assign stall      = (ex_valid & ~ex_ready_q) | (state_q != S_IDLE);
    assign dbg_state  = state_q;

endmodule
